stream_width_downsizer: RTL and testbench

Serializes wide valid/ready stream words into a sequence of narrow beats. One IN word of OUT_WIDTH*RATIO bits becomes RATIO output beats, with the word's last flag carried on the final beat. It sits directly downstream of the skid buffer and consumes its out_data/out_valid/out_ready interface. It feeds narrow AXI-Stream-style sinks at one beat per cycle with no bubbles between words.

---
 rtl/stream_width_downsizer.sv | 190 +++++++++++++++++++
 tb/tb_stream_width_downsizer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_width_downsizer.sv
// stream_width_downsizer: serializes one OUT_WIDTH*RATIO-bit word into RATIO
// narrow beats. The word's last flag is carried on its final beat only.
// Beats are registered, so there is no combinational in_data -> out_data path.
// The only combinational path is out_ready -> in_ready, which lets a new word
// load on the same edge the final beat leaves, so words follow without a gap.

module stream_width_downsizer #(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [OUT_WIDTH*RATIO-1:0]    in_data,
    input  logic                          in_last,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int IN_WIDTH = OUT_WIDTH * RATIO;
    localparam int IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);
    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    typedef enum logic [0:0] {
        EMPTY  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t               state_r;
    logic [IDX_W-1:0]     idx_r;
    logic [IN_WIDTH-1:0]  word_r;
    logic                 last_r;
    logic                 past_reset_r;

    logic                 rx_s;
    logic                 tx_s;
    logic                 final_beat_s;
    logic [IDX_W-1:0]     next_idx_s;

    // Picks beat number 'beat' of a word, honouring the emission order.
    function automatic logic [OUT_WIDTH-1:0] slice_f(
        input logic [IN_WIDTH-1:0] word,
        input logic [IDX_W-1:0]    beat
    );
        int pos;
        pos = MSB_FIRST ? (RATIO - 1 - int'(beat)) : int'(beat);
        return word[pos*OUT_WIDTH +: OUT_WIDTH];
    endfunction

    assign rx_s         = in_valid && in_ready;
    assign tx_s         = out_valid && out_ready;
    assign final_beat_s = (idx_r == LAST_IDX);
    assign next_idx_s   = idx_r + ONE_IDX;

    // Accept when empty, or when the final beat leaves this very cycle.
    always_comb begin
        in_ready = 1'b0;
        if (past_reset_r) begin
            in_ready = 1'b0;
        end else if (state_r == EMPTY) begin
            in_ready = 1'b1;
        end else begin
            in_ready = final_beat_s && out_ready;
        end
    end

    // Keeps in_ready low for the first edge after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            past_reset_r <= 1'b1;
        end else begin
            past_reset_r <= 1'b0;
        end
    end

    // Beat sequencer: load a word, walk the beat index, register each beat.
    // Because in_ready is only high when empty or at a departing final beat,
    // an accepted word always means "load now".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= EMPTY;
            idx_r     <= ZERO_IDX;
            word_r    <= {IN_WIDTH{1'b0}};
            last_r    <= 1'b0;
            out_data  <= {OUT_WIDTH{1'b0}};
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (rx_s) begin
            state_r   <= ACTIVE;
            idx_r     <= ZERO_IDX;
            word_r    <= in_data;
            last_r    <= in_last;
            out_data  <= slice_f(in_data, ZERO_IDX);
            out_last  <= in_last && (LAST_IDX == ZERO_IDX);
            out_valid <= 1'b1;
        end else if (tx_s && final_beat_s) begin
            state_r   <= EMPTY;
            idx_r     <= ZERO_IDX;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (tx_s) begin
            idx_r     <= next_idx_s;
            out_data  <= slice_f(word_r, next_idx_s);
            out_last  <= last_r && (next_idx_s == LAST_IDX);
        end
    end

`ifdef FORMAL
    stream_width_downsizer_checker #(
        .OUT_WIDTH (OUT_WIDTH),
        .RATIO     (RATIO),
        .IDX_W     (IDX_W)
    ) u_checker (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .active    (state_r == ACTIVE),
        .idx       (idx_r)
    );
`endif

endmodule

`ifdef FORMAL
// Property checker for stream_width_downsizer.
module stream_width_downsizer_checker #(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4,
    parameter int IDX_W     = 2
) (
    input logic                 clk,
    input logic                 reset,
    input logic                 in_valid,
    input logic                 in_ready,
    input logic                 in_last,
    input logic                 out_valid,
    input logic                 out_ready,
    input logic [OUT_WIDTH-1:0] out_data,
    input logic                 out_last,
    input logic                 active,
    input logic [IDX_W-1:0]     idx
);
    logic [31:0] words_in_r;
    logic [31:0] beats_out_r;
    logic        cap_last_r;
    logic [31:0] remaining_s;

    assign remaining_s = active ? (32'(RATIO) - 32'(idx)) : 32'd0;

    // Counts accepted words and transferred beats, remembers the held last flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            words_in_r  <= 32'd0;
            beats_out_r <= 32'd0;
            cap_last_r  <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                words_in_r <= words_in_r + 32'd1;
                cap_last_r <= in_last;
            end
            if (out_valid && out_ready) begin
                beats_out_r <= beats_out_r + 32'd1;
            end
        end
    end

    a_conservation: assert property (@(posedge clk) disable iff (reset)
        beats_out_r == 32'(RATIO) * words_in_r - remaining_s);
    a_valid_active: assert property (@(posedge clk) disable iff (reset)
        out_valid |-> active);
    a_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));
    a_last_final: assert property (@(posedge clk) disable iff (reset)
        (out_valid && out_ready && idx == IDX_W'(RATIO - 1)) |-> (out_last == cap_last_r));
    a_last_inner: assert property (@(posedge clk) disable iff (reset)
        (out_valid && out_ready && idx != IDX_W'(RATIO - 1)) |-> !out_last);
endmodule
`endif

// File: tb/tb_stream_width_downsizer.sv
// Bench for stream_width_downsizer: a LSB-first RATIO=4 instance and a
// MSB-first RATIO=4 instance share one input stream; a RATIO=1 instance runs
// its own stream. Expected beats are queued at issue and popped by monitors.

module tb_stream_width_downsizer;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] in_data;
    logic        in_last;
    logic        in_valid;
    logic        out_ready;
    logic        in_ready0, in_ready1;
    logic [7:0]  out_data0, out_data1;
    logic        out_last0, out_last1;
    logic        out_valid0, out_valid1;

    logic [7:0]  r_in_data;
    logic        r_in_last;
    logic        r_in_valid;
    logic        r_in_ready;
    logic [7:0]  r_out_data;
    logic        r_out_last;
    logic        r_out_valid;
    logic        r_out_ready;

    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [8:0]  q2[$];

    int          n_cmp = 0;
    int          n_err = 0;
    bit          rnd_en = 1'b0;

    always #5 clk = ~clk;

    stream_width_downsizer #(.OUT_WIDTH(8), .RATIO(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready0),
        .out_data(out_data0), .out_last(out_last0), .out_valid(out_valid0), .out_ready(out_ready)
    );

    stream_width_downsizer #(.OUT_WIDTH(8), .RATIO(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready1),
        .out_data(out_data1), .out_last(out_last1), .out_valid(out_valid1), .out_ready(out_ready)
    );

    stream_width_downsizer #(.OUT_WIDTH(8), .RATIO(1), .MSB_FIRST(1'b0)) dut_r1 (
        .clk(clk), .reset(reset),
        .in_data(r_in_data), .in_last(r_in_last), .in_valid(r_in_valid), .in_ready(r_in_ready),
        .out_data(r_out_data), .out_last(r_out_last), .out_valid(r_out_valid), .out_ready(r_out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: pop one expected beat per handshake.
    always @(negedge clk) begin : mon0
        logic [8:0] e;
        if (!reset && out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL mon_lsb_extra: got beat %02h expected none", out_data0);
            end else begin
                e = q0.pop_front();
                chk("mon_lsb_data", 32'(out_data0), 32'(e[7:0]));
                chk("mon_lsb_last", 32'(out_last0), 32'(e[8]));
            end
        end
    end

    always @(negedge clk) begin : mon1
        logic [8:0] e;
        if (!reset && out_valid1 && out_ready) begin
            if (q1.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL mon_msb_extra: got beat %02h expected none", out_data1);
            end else begin
                e = q1.pop_front();
                chk("mon_msb_data", 32'(out_data1), 32'(e[7:0]));
                chk("mon_msb_last", 32'(out_last1), 32'(e[8]));
            end
        end
    end

    always @(negedge clk) begin : mon2
        logic [8:0] e;
        if (!reset && r_out_valid && r_out_ready) begin
            if (q2.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL mon_r1_extra: got beat %02h expected none", r_out_data);
            end else begin
                e = q2.pop_front();
                chk("mon_r1_data", 32'(r_out_data), 32'(e[7:0]));
                chk("mon_r1_last", 32'(r_out_last), 32'(e[8]));
            end
        end
    end

    // Random sink readiness for the RATIO=1 instance while enabled.
    initial begin
        r_out_ready = 1'b1;
        @(posedge rnd_en);
        while (rnd_en) begin
            @(posedge clk);
            #1;
            r_out_ready = 1'($urandom_range(0, 1));
        end
        r_out_ready = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Issue one word to both RATIO=4 instances; acc_d is out_data0 at acceptance.
    task automatic send(input logic [31:0] d, input logic l, output logic [7:0] acc_d);
        int n;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            q0.push_back({l && (k == 3), d[8*k +: 8]});
            q1.push_back({l && (k == 3), d[8*(3-k) +: 8]});
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready0 && n < 200);
        chk("send_accept", 32'(in_ready0), 32'd1);
        acc_d = out_data0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_r1(input logic [7:0] d, input logic l);
        int n;
        r_in_data  = d;
        r_in_last  = l;
        r_in_valid = 1'b1;
        q2.push_back({l, d});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!r_in_ready && n < 200);
        chk("send_r1_accept", 32'(r_in_ready), 32'd1);
        @(posedge clk);
        #1;
        r_in_valid = 1'b0;
    endtask

    initial begin : stim
        logic [7:0] acc;
        logic [7:0] t3_exp [7];
        bit         t3_rdy [7];
        bit         r1_last [5];
        int         n;

        t3_exp = '{8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hCC, 8'hCC, 8'hDD};
        t3_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        r1_last = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        reset      = 1'b1;
        in_data    = 32'h0;
        in_last    = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        r_in_data  = 8'h00;
        r_in_last  = 1'b0;
        r_in_valid = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_out_last", 32'(out_last0), 32'd0);
        chk("rst_out_data", 32'(out_data0), 32'd0);
        chk("rst_in_ready", 32'(in_ready0), 32'd0);
        chk("rst_r1_in_ready", 32'(r_in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready0), 32'd0);
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready0), 32'd1);
        @(posedge clk);
        #1;

        // Single word, sink always ready
        send(32'h44332211, 1'b1, acc);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_valid", 32'(out_valid0), 32'd1);
            chk("t1_in_ready", 32'(in_ready0), 32'(k == 3));
            chk("t1_last", 32'(out_last0), 32'(k == 3));
        end
        @(negedge clk);
        chk("t1_idle", 32'(out_valid0), 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back words, no bubble
        send(32'h03020100, 1'b0, acc);
        send(32'h07060504, 1'b1, acc);
        chk("t2_accept_beat", 32'(acc), 32'h03);
        @(negedge clk);
        chk("t2_no_gap_valid", 32'(out_valid0), 32'd1);
        chk("t2_no_gap_data", 32'(out_data0), 32'h04);
        repeat (5) @(posedge clk);
        #1;

        // Backpressure pattern 1,0,0,1,0,1,1
        send(32'hDDCCBBAA, 1'b0, acc);
        for (int c = 0; c < 7; c++) begin
            out_ready = t3_rdy[c];
            @(negedge clk);
            chk("t3_data", 32'(out_data0), 32'(t3_exp[c]));
            chk("t3_in_ready", 32'(in_ready0), 32'(c == 6));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset after beat 22 has transferred
        send(32'h44332211, 1'b1, acc);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("t4_valid_async", 32'(out_valid0), 32'd0);
        chk("t4_msb_valid_async", 32'(out_valid1), 32'd0);
        chk("t4_in_ready", 32'(in_ready0), 32'd0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t4_ready_hold", 32'(in_ready0), 32'd0);
        @(negedge clk);
        chk("t4_ready_back", 32'(in_ready0), 32'd1);
        @(posedge clk);
        #1;
        send(32'h88776655, 1'b0, acc);
        repeat (6) @(posedge clk);
        #1;

        // RATIO=1 stream with random sink readiness
        rnd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_r1(8'(i + 1), r1_last[i]);
        end
        n = 0;
        while (q2.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        rnd_en = 1'b0;

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || q2.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_lsb", 32'(q0.size()), 32'd0);
        chk("drain_msb", 32'(q1.size()), 32'd0);
        chk("drain_r1", 32'(q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
